// File: rtl/sdram_rd_arbiter_pkg.sv
// sdram_rd_arbiter_pkg: shared state/owner encodings and default widths for the SDRAM read arbiter
package sdram_rd_arbiter_pkg;
  localparam int ADDR_W_DEF = 24;
  localparam int BURST_LEN_DEF = 64;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARB = 3'd1;
  localparam logic [2:0] ST_REQ = 3'd2;
  localparam logic [2:0] ST_XFER = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;
  localparam logic OWN_DISP = 1'b0;
  localparam logic OWN_AUX = 1'b1;
endpackage

// File: rtl/sdram_rd_grant.sv
// sdram_rd_grant: display/aux eligibility, urgency and round-robin grant with last_grant register
module sdram_rd_grant
  import sdram_rd_arbiter_pkg::*;
#(
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_AW = 9,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int LOW_WM = 128,
  parameter int CNT_W = $clog2(FRAME_WORDS + 1)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             armed,
  input  logic [CNT_W-1:0] disp_cnt,
  input  logic [FIFO_AW:0] disp_usedw,
  input  logic             aux_req,
  output logic             gnt_disp,
  output logic             gnt_aux
);
  logic last_grant, disp_elig, urgent;
  always_comb begin
    disp_elig = armed && 32'(disp_cnt) < 32'(FRAME_WORDS) && 32'(disp_usedw) <= 32'((1 << FIFO_AW) - BURST_LEN);
    urgent = disp_elig && 32'(disp_usedw) < 32'(LOW_WM);
    gnt_disp = urgent || (disp_elig && (!aux_req || last_grant == OWN_AUX));
    gnt_aux = aux_req && !gnt_disp;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= OWN_AUX;
    else if (en && (gnt_disp || gnt_aux)) last_grant <= gnt_disp ? OWN_DISP : OWN_AUX;
endmodule

// File: rtl/sdram_rd_arbiter.sv
// sdram_rd_arbiter: shares the SDRAM read port between the frame-aligned display prefetch and an aux burst requester
module sdram_rd_arbiter
  import sdram_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_AW = 9,
  parameter int LOW_WM = 128
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              src_sel,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic [FIFO_AW:0]  disp_usedw,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_len,
  output logic              aux_done,
  output logic              aux_wr,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [7:0]        sdram_rd_len,
  input  logic              sdram_rd_ack,
  input  logic              sdram_rd_valid,
  output logic              disp_fifo_wr,
  output logic              disp_fifo_clr,
  output logic              busy
);
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  logic [2:0] state;
  logic src_cur, armed, frame_pending, switch_pending, owner;
  logic [ADDR_W-1:0] disp_addr;
  logic [CNT_W-1:0] disp_cnt;
  logic [7:0] xfer_cnt, disp_len, aux_len1;
  logic [31:0] remain;
  logic in_arb, in_xfer, frame_now, switch_now, arb_grant, last_word, gnt_disp, gnt_aux;
  always_comb begin
    in_arb = state == ST_ARB;
    in_xfer = state == ST_XFER;
    frame_now = frame_pending || frame_start;
    switch_now = switch_pending || src_sel != src_cur;
    arb_grant = in_arb && !switch_now && !frame_now;
    remain = 32'(FRAME_WORDS) - 32'(disp_cnt);
    disp_len = remain < 32'(BURST_LEN) ? remain[7:0] : 8'(BURST_LEN);
    aux_len1 = aux_len == 8'd0 ? 8'd1 : aux_len;
    last_word = in_xfer && sdram_rd_valid && xfer_cnt == sdram_rd_len - 8'd1;
  end
  assign sdram_rd_req = state == ST_REQ;
  assign busy = state == ST_REQ || in_xfer;
  assign disp_fifo_clr = state == ST_FLUSH;
  assign disp_fifo_wr = in_xfer && sdram_rd_valid && owner == OWN_DISP;
  assign aux_wr = in_xfer && sdram_rd_valid && owner == OWN_AUX;
  sdram_rd_grant #(
    .FRAME_WORDS(FRAME_WORDS), .FIFO_AW(FIFO_AW), .BURST_LEN(BURST_LEN), .LOW_WM(LOW_WM), .CNT_W(CNT_W)
  ) u_grant (
    .clk(clk), .rst_n(rst_n), .en(arb_grant), .armed(armed), .disp_cnt(disp_cnt),
    .disp_usedw(disp_usedw), .aux_req(aux_req && !aux_done), .gnt_disp(gnt_disp), .gnt_aux(gnt_aux)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      src_cur <= 1'b0;
      armed <= 1'b0;
      frame_pending <= 1'b0;
      switch_pending <= 1'b0;
      owner <= OWN_DISP;
      disp_addr <= '0;
      disp_cnt <= '0;
      xfer_cnt <= '0;
      sdram_rd_addr <= '0;
      sdram_rd_len <= '0;
      aux_done <= 1'b0;
    end else begin
      aux_done <= last_word && owner == OWN_AUX;
      if (!in_arb) begin
        frame_pending <= frame_pending || frame_start;
        switch_pending <= switch_pending || src_sel != src_cur;
      end
      case (state)
        ST_IDLE: state <= ST_ARB;
        ST_ARB:
          if (switch_now) begin
            src_cur <= src_sel;
            armed <= 1'b0;
            switch_pending <= 1'b0;
            frame_pending <= frame_now;
            state <= ST_FLUSH;
          end else if (frame_now) begin
            disp_addr <= src_cur ? base1 : base0;
            disp_cnt <= '0;
            armed <= 1'b1;
            frame_pending <= 1'b0;
            state <= ST_FLUSH;
          end else if (gnt_disp || gnt_aux) begin
            owner <= gnt_disp ? OWN_DISP : OWN_AUX;
            sdram_rd_addr <= gnt_disp ? disp_addr : aux_addr;
            sdram_rd_len <= gnt_disp ? disp_len : aux_len1;
            xfer_cnt <= '0;
            state <= ST_REQ;
          end
        ST_REQ: if (sdram_rd_ack) state <= ST_XFER;
        ST_XFER:
          if (sdram_rd_valid) begin
            xfer_cnt <= xfer_cnt + 8'd1;
            if (last_word) begin
              state <= ST_ARB;
              if (owner == OWN_DISP) begin
                disp_addr <= disp_addr + ADDR_W'(sdram_rd_len);
                disp_cnt <= disp_cnt + CNT_W'(sdram_rd_len);
              end
            end
          end
        default: state <= ST_ARB;
      endcase
    end
endmodule

// File: doc/sdram_rd_arbiter.md
Name: sdram_rd_arbiter

Overview:
- Schedules and shares the single SDRAM read port between two requesters:
  - the display prefetch stream, which fills the video read FIFO from one of two frame buffers selected by game state;
  - an auxiliary burst requester (sprite/score loader).
- Aligns the display stream to frame start.
- Flushes the display FIFO when the frame-buffer source changes.
- Sits between the game-state logic / VGA timing and the SDRAM controller read interface.

Parameters:
- ADDR_W, 24, SDRAM word-address width
- BURST_LEN, 64, display burst length in words (≤255)
- FRAME_WORDS, 307200, words per display frame
- FIFO_AW, 9, display FIFO address width; depth = 2**FIFO_AW
- LOW_WM, 128, display-urgent threshold on FIFO fill level

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- frame_start  in  1  one-cycle pulse at start of each video frame
- src_sel  in  1  frame-buffer select (0 = buffer 0, 1 = buffer 1)
- base0  in  ADDR_W  start address of buffer 0
- base1  in  ADDR_W  start address of buffer 1
- disp_usedw  in  FIFO_AW+1  display FIFO fill level
- aux_req  in  1  aux burst request, level, held until aux_done
- aux_addr  in  ADDR_W  aux start address, stable while aux_req is high
- aux_len  in  8  aux word count
- aux_done  out  1  one-cycle pulse, aux burst complete
- aux_wr  out  1  aux data-word strobe
- sdram_rd_req  out  1  read command request
- sdram_rd_addr  out  ADDR_W  read start address
- sdram_rd_len  out  8  read word count
- sdram_rd_ack  in  1  command accepted (one cycle)
- sdram_rd_valid  in  1  read data word valid
- disp_fifo_wr  out  1  display FIFO write strobe
- disp_fifo_clr  out  1  one-cycle display FIFO flush pulse
- busy  out  1  high in REQ or XFER

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; src_cur=0; armed=0; disp_addr=0; disp_cnt=0; last_grant=aux; all pending flags 0.
- Reset mid-operation clears everything immediately, including dropping sdram_rd_req.
- States:
  - IDLE: leaves to ARB on the cycle after reset release.
  - ARB: grants and loads a command; next cycle REQ.
  - REQ: sdram_rd_req=1 with addr/len stable; go to XFER on the cycle sdram_rd_ack=1.
  - XFER: count sdram_rd_valid words to len; after last word return to ARB.
  - FLUSH: one cycle; disp_fifo_clr=1; then ARB.
- Data routing: disp_fifo_wr and aux_wr equal sdram_rd_valid gated by current owner, combinational, zero latency. A valid word outside XFER is dropped.
- frame_start:
  - Seen in ARB, or latched as frame_pending during REQ/XFER, and applied in ARB before any grant.
  - Action: disp_addr <= (src_cur ? base1 : base0), disp_cnt <= 0, armed <= 1, go to FLUSH.
- Source switch:
  - src_sel != src_cur sets switch_pending.
  - In ARB: src_cur <= src_sel, armed <= 0, go to FLUSH.
  - A burst in flight always completes first.
  - If switch and frame are both pending, the switch is applied first and frame_pending is kept. The frame is applied on the next ARB visit.
- Eligibility:
  - Display: armed && disp_cnt < FRAME_WORDS && disp_usedw <= 2**FIFO_AW − BURST_LEN.
  - Aux: aux_req.
- Priority:
  - Display wins if eligible and disp_usedw < LOW_WM.
  - Otherwise, if both are eligible, grant alternates against last_grant.
  - If neither is eligible, stay in ARB.
- Display length: len = min(BURST_LEN, FRAME_WORDS − disp_cnt). On completion disp_addr += len and disp_cnt += len.
- Frame end: at disp_cnt == FRAME_WORDS the display is ineligible until the next frame_start.
- Aux length: aux_len = 0 is treated as 1. aux_done pulses the cycle after the last aux word.
- Arithmetic: disp_addr wraps modulo 2**ADDR_W. disp_cnt is sized for FRAME_WORDS.
- Latency: grant-eligible ARB cycle → sdram_rd_req high on the next cycle.

Decomposition:
- Shared package:
  - state encoding (IDLE/ARB/REQ/XFER/FLUSH);
  - owner encoding (DISP/AUX);
  - default ADDR_W and BURST_LEN.
- One natural sub-module, sdram_rd_grant: the combinational eligibility and priority/round-robin decision plus the last_grant register.

Test Plan:
Bench settings: BURST_LEN=64, FRAME_WORDS=200, FIFO_AW=9, LOW_WM=128; ack 2 cycles after req; valid every cycle.
1. Reset, base0=0x1000, frame_start, disp_usedw=0 → disp_fifo_clr pulse; bursts at 0x1000/0x1040/0x1080 with len 64, then 0x10C0 len 8; disp_fifo_wr count = 200; no further req until the next frame_start.
2. disp_usedw=460 (>448) → no display req; drop to 448 → req within 2 cycles.
3. disp_usedw=300, aux_req with aux_addr=0x8000, len=16, both eligible → grants alternate disp/aux; aux_wr count 16; aux_done pulse one cycle after the 16th word.
4. disp_usedw=50 with aux_req pending → display granted every time (urgent) until disp_usedw ≥ 128.
5. src_sel 0→1 mid display burst → burst completes (64 disp_fifo_wr); one disp_fifo_clr; no display req until frame_start; then first addr = base1.
6. Assert rst_n low during XFER → sdram_rd_req, busy, disp_fifo_wr 0 immediately; after release no req until frame_start.
